// File: rtl/fir_input_feeder_if.sv
// Handshake bundle between the sample source, the feeder and the FIR core:
// upstream valid/ready stream plus the issue pulse / done return to the core.
interface fir_input_feeder_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] fir_data;
    logic                  fir_valid;
    logic                  fir_done;

    // Environment side: sample source and FIR core.
    modport master (
        output s_data, s_valid, fir_done,
        input  s_ready, fir_data, fir_valid
    );

    // Feeder side.
    modport slave (
        input  s_data, s_valid, fir_done,
        output s_ready, fir_data, fir_valid
    );
endinterface

// File: rtl/fir_input_feeder.sv
// Buffers upstream samples in a small FIFO and issues them one at a time to the FIR core.
// Optional watchdog on the done return is enabled with FIR_FEEDER_TIMEOUT_EN.
module fir_input_feeder #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned INPUT_LENGTH   = 221184,
    parameter int unsigned COUNT_WIDTH    = $clog2(INPUT_LENGTH + 1),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    fir_input_feeder_if.slave      bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic                   frame_full,
    output logic                   timeout_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop;

    logic [1:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  fir_data_q, fir_data_d;
    logic                   fir_valid_q;
    logic                   busy_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   frame_full_q, frame_full_d;

`ifdef FIR_FEEDER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;
`endif

    // Wrap bit of the pointers separates full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = bus.s_valid && !fifo_full;
    assign wr_ptr_d   = wr_ptr_q + PW'(push);
    assign rd_ptr_d   = rd_ptr_q + PW'(pop);
    assign fir_data_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : fir_data_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.s_data;
        end
    end

    // Next-state: a pop happens on every transition into ISSUE.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        count_d      = count_q;
        frame_full_d = frame_full_q;
`ifdef FIR_FEEDER_TIMEOUT_EN
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !frame_full_q) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                count_d = count_q + COUNT_WIDTH'(1);
                if (count_d == COUNT_WIDTH'(INPUT_LENGTH)) begin
                    frame_full_d = 1'b1;
                end
`ifdef FIR_FEEDER_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.fir_done) begin
                    if (!fifo_empty && !frame_full_q) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`ifdef FIR_FEEDER_TIMEOUT_EN
                else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fir_data_q   <= '0;
            fir_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
            frame_full_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fir_data_q   <= fir_data_d;
            fir_valid_q  <= (state_d == S_ISSUE);
            busy_q       <= (state_d != S_IDLE);
            count_q      <= count_d;
            frame_full_q <= frame_full_d;
        end
    end

`ifdef FIR_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    // Keeps the parameter list identical across builds.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_err    = 1'b0;
`endif

    assign bus.s_ready   = !fifo_full;
    assign bus.fir_data  = fir_data_q;
    assign bus.fir_valid = fir_valid_q;
    assign busy          = busy_q;
    assign sample_count  = count_q;
    assign frame_full    = frame_full_q;
endmodule

// File: tb/tb_fir_input_feeder.sv
// Bench for fir_input_feeder: directed vector table, corner-case sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_fir_input_feeder;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int LEN   = 12;
    localparam int TO    = 16;
    localparam int CW    = $clog2(LEN + 1);
`ifdef FIR_FEEDER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          busy, frame_full, timeout_err;
    logic [CW-1:0] sample_count;

    fir_input_feeder_if #(.DATA_WIDTH(DW)) bus ();

    fir_input_feeder #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .INPUT_LENGTH  (LEN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .sample_count(sample_count),
        .frame_full  (frame_full),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic fv, input logic bz, input logic rdy,
                                         input logic ff, input logic te,
                                         input logic [CW-1:0] cnt, input logic [DW-1:0] d);
        return 64'({fv, bz, rdy, ff, te, cnt, d});
    endfunction

    function automatic logic [63:0] dut_pack();
        return pack(bus.fir_valid, busy, bus.s_ready, frame_full, timeout_err,
                    sample_count, bus.fir_data);
    endfunction

    // Reference model: a sample queue plus "last issue edge" bookkeeping.
    logic [DW-1:0] mq[$];
    bit            m_wait;
    int            m_ie, m_edge, m_cnt;
    logic [DW-1:0] m_data;
    bit            m_terr;

    task automatic model_reset();
        mq.delete();
        m_wait = 1'b0;
        m_ie   = -100;
        m_edge = 0;
        m_cnt  = 0;
        m_data = '0;
        m_terr = 1'b0;
    endtask

    task automatic model_edge(input bit sv, input logic [DW-1:0] sd, input bit fd);
        int sz;
        bit rdy;
        bit issue;
        m_edge++;
        sz    = mq.size();
        rdy   = (sz < DEPTH);
        issue = 1'b0;
        if (!m_wait) begin
            issue = (sz > 0) && (m_cnt < LEN);
        end else if (m_edge >= m_ie + 2) begin
            if (fd) begin
                if (sz > 0 && m_cnt < LEN) issue = 1'b1;
                else m_wait = 1'b0;
            end else if (TO_EN && (m_edge == m_ie + 1 + TO)) begin
                m_wait = 1'b0;
                m_terr = 1'b1;
            end
        end
        if (issue) begin
            m_data = mq.pop_front();
            m_wait = 1'b1;
            m_ie   = m_edge;
            m_cnt++;
        end
        if (sv && rdy) mq.push_back(sd);
    endtask

    function automatic logic [63:0] model_pack();
        int c;
        bit fv;
        fv = (m_ie == m_edge);
        c  = m_cnt - (fv ? 1 : 0);
        return pack(fv, m_wait, mq.size() < DEPTH, c == LEN, m_terr, CW'(c), m_data);
    endfunction

    // Stimulus state shared by the cycle task.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] iss_q[$];
    int            iss_cyc[$];
    int            rsp_delay;
    bit            man_done;
    bit            rnd_mode;
    int            since_v;
    int            cyc_no = 0;

    task automatic cyc();
        bit            sv, fd, acc;
        logic [DW-1:0] sd;
        sv = (src_q.size() > 0) && (!rnd_mode || ($urandom_range(0, 2) != 0));
        sd = sv ? src_q[0] : DW'($urandom);
        if (rnd_mode)            fd = ($urandom_range(0, 3) == 0);
        else if (rsp_delay >= 0) fd = (since_v == rsp_delay);
        else                     fd = man_done;
        bus.s_valid  = sv;
        bus.s_data   = sd;
        bus.fir_done = fd;
        acc = sv && bus.s_ready;
        model_edge(sv, sd, fd);
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        check($sformatf("cycle%0d", cyc_no), dut_pack(), model_pack());
        if (acc) void'(src_q.pop_front());
        if (bus.fir_valid) begin
            iss_q.push_back(bus.fir_data);
            iss_cyc.push_back(cyc_no);
            since_v = 0;
        end else begin
            since_v++;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_data   = 16'hFFFF;
        bus.fir_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", dut_pack(), pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(0), DW'(0)));
        model_reset();
        src_q.delete();
        iss_q.delete();
        iss_cyc.delete();
        since_v      = 1 << 20;
        rsp_delay    = -1;
        man_done     = 1'b0;
        rnd_mode     = 1'b0;
        bus.s_valid  = 1'b0;
        bus.fir_done = 1'b0;
        reset        = 1'b1;
    endtask

    typedef struct {
        bit            sv;
        logic [DW-1:0] sd;
        bit            fd;
        bit            fv;
        logic [DW-1:0] fdat;
        bit            bz;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.fir_done = 1'b0;

        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, CW'(0)};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, CW'(0)};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1, CW'(1)};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, CW'(1)};
        tbl[4] = '{1'b1, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b0, CW'(1)};
        tbl[5] = '{1'b1, 16'h5555, 1'b0, 1'b1, 16'hABCD, 1'b1, CW'(1)};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hABCD, 1'b1, CW'(2)};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h5555, 1'b1, CW'(2)};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h5555, 1'b1, CW'(3)};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5555, 1'b0, CW'(3)};

        // Directed vectors straight after reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.s_valid  = tbl[i].sv;
            bus.s_data   = tbl[i].sd;
            bus.fir_done = tbl[i].fd;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_pack(),
                  pack(tbl[i].fv, tbl[i].bz, 1'b1, 1'b0, 1'b0, tbl[i].cnt, tbl[i].fdat));
        end

        // Back-to-back issue with a slow core.
        do_reset();
        for (int i = 1; i <= 5; i++) src_q.push_back(DW'(i));
        rsp_delay = 200;
        for (int k = 0; k < 2000 && !(iss_q.size() == 5 && !busy); k++) cyc();
        check("b2b_count", 64'(iss_q.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            check($sformatf("b2b_data%0d", i),
                  (i < iss_q.size()) ? 64'(iss_q[i]) : 64'hDEAD, 64'(i + 1));
        for (int i = 1; i < 5; i++)
            check($sformatf("b2b_gap%0d", i),
                  (i < iss_cyc.size()) ? 64'(iss_cyc[i] - iss_cyc[i-1]) : 64'hDEAD, 64'(201));

        // Backpressure with the core stalled.
        do_reset();
        for (int i = 0; i < 10; i++) src_q.push_back(DW'(16'h0100 + i));
        repeat (15) cyc();
        check("bp_issued", 64'(iss_q.size()), 64'(1));
        check("bp_held", 64'(src_q.size()), 64'(1));
        check("bp_ready", 64'(bus.s_ready), 64'(0));
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        check("bp_next_issue", 64'(iss_q.size()), 64'(2));
        cyc();
        check("bp_tenth_accepted", 64'(src_q.size()), 64'(0));
        rsp_delay = 2;
        for (int k = 0; k < 200 && iss_q.size() < 10; k++) cyc();
        for (int i = 0; i < 10; i++)
            check($sformatf("bp_order%0d", i),
                  (i < iss_q.size()) ? 64'(iss_q[i]) : 64'hDEAD, 64'(16'h0100 + i));

        // Frame limit: issuing stops, FIFO keeps filling then backpressures.
        do_reset();
        for (int i = 0; i < LEN + 2; i++) src_q.push_back(DW'(16'h0200 + i));
        rsp_delay = 3;
        repeat (150) cyc();
        check("frame_issues", 64'(iss_q.size()), 64'(LEN));
        check("frame_full", 64'(frame_full), 64'(1));
        check("frame_count", 64'(sample_count), 64'(LEN));
        rsp_delay = -1;
        man_done  = 1'b1;
        cyc();
        man_done  = 1'b0;
        cyc();
        check("frame_done_ignored", 64'(iss_q.size()), 64'(LEN));
        for (int i = 0; i < DEPTH - 1; i++) src_q.push_back(DW'(16'h0300 + i));
        repeat (20) cyc();
        check("frame_fill_left", 64'(src_q.size()), 64'(1));
        check("frame_ready", 64'(bus.s_ready), 64'(0));

        // Watchdog: no done after a single issue.
        do_reset();
        src_q.push_back(16'h0777);
        repeat (3 + TO + 2) cyc();
        check("to_err", 64'(timeout_err), 64'(TO_EN));
        check("to_busy", 64'(busy), 64'(!TO_EN));

        // Asynchronous reset while waiting with a full FIFO.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) src_q.push_back(DW'(16'h0400 + i));
        repeat (14) cyc();
        check("ar_ready_pre", 64'(bus.s_ready), 64'(0));
        check("ar_busy_pre", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1 check("ar_async_clear", dut_pack(),
                 pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(0), DW'(0)));
        do_reset();
        repeat (10) cyc();
        check("ar_no_issue", 64'(iss_q.size()), 64'(0));

        // Randomized traffic against the model.
        for (int e = 0; e < 6; e++) begin
            do_reset();
            for (int i = 0; i < 40; i++) src_q.push_back(DW'($urandom));
            rnd_mode = 1'b1;
            repeat (300) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_input_feeder.md
# fir_input_feeder

Upstream stage of the FIR filter core. Accepts a streaming sample interface with a valid/ready handshake, buffers samples in a small FIFO, and hands them to the FIR core one at a time. Each sample is issued as a single-cycle `fir_valid` pulse with data held stable, and the next sample is not issued until the core signals completion on `fir_done`. It also counts issued samples and stops at the core's input-RAM capacity.

## Interface
- `DATA_WIDTH`, 16, sample width; matches the FIR input width.
- `FIFO_DEPTH`, 8, buffer entries; power of two, ≥2.
- `INPUT_LENGTH`, 221184, samples per frame; the FIR input-RAM capacity.
- `COUNT_WIDTH`, `$clog2(INPUT_LENGTH+1)`, width of `sample_count`.
- `TIMEOUT_CYCLES`, 1024, watchdog limit; used only with `FIR_FEEDER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `s_data` in DATA_WIDTH: upstream sample.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: FIFO can accept; equals `!full`.
- `fir_data` out DATA_WIDTH: drives FIR `FIR_input`; registered.
- `fir_valid` out 1: drives FIR `input_Valid`; one-cycle pulse, registered.
- `fir_done` in 1: from FIR `output_Valid`.
- `busy` out 1: high in ISSUE and WAIT.
- `sample_count` out COUNT_WIDTH: samples issued since reset.
- `frame_full` out 1: sticky; `sample_count == INPUT_LENGTH`.
- `timeout_err` out 1: sticky watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- Reset value of every output is 0, except `s_ready`, which is 1 because the FIFO is empty. The FIFO is empty and the state is IDLE.
- **FIFO**
  - A push occurs when `s_valid && s_ready` at a clock edge. A pop occurs on every transition into ISSUE.
  - Pointers use `$clog2(FIFO_DEPTH)+1` bits, and the wrap bit distinguishes full from empty.
  - A push and a pop on the same edge is legal when the FIFO is non-empty; occupancy is unchanged.
  - `s_data` while `s_ready=0` is ignored. No overflow is possible.
- **FSM**
  - IDLE: if the FIFO is non-empty and `frame_full=0`, pop the head into `fir_data` and go to ISSUE.
  - ISSUE: `fir_valid=1` for exactly this cycle. Increment `sample_count`; if it reaches `INPUT_LENGTH`, set `frame_full`. Go to WAIT.
  - WAIT: `fir_data` is held. When `fir_done=1`:
    - If the FIFO is non-empty and `frame_full=0`, pop and go to ISSUE (back-to-back).
    - Otherwise, go to IDLE.
- `fir_done` is ignored outside WAIT. It has no effect on the counter.
- `fir_data` changes only on a pop, and keeps its last value otherwise.
- When `frame_full=1`, issuing stops permanently until reset. The FIFO still accepts samples until it is full, then backpressures.
- Reset mid-operation returns the block to IDLE immediately and asynchronously. FIFO contents are discarded, and the count and flags are cleared.

## Timing
- Push at edge t into an empty FIFO in IDLE: pop and ISSUE at edge t+1, so `fir_valid` is high in cycle t+1..t+2.
- This holds `fir_data` valid during the FIR's Idle cycle and its following write cycle, since the data is held through WAIT.
- `fir_done` high in cycle k (sampled at edge k+1) with the FIFO non-empty: the next `fir_valid` is high in the cycle after edge k+1. This is the FIR's first Idle cycle after its done state, with zero dead cycles.
- `s_ready` is combinational from the registered pointers only. There is no path from `s_valid` to `s_ready`.

## Configuration
- `FIR_FEEDER_TIMEOUT_EN` defined:
  - A cycle counter runs while in WAIT and is cleared on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `fir_done`, set `timeout_err` (sticky) and go to IDLE. The held sample is dropped and `sample_count` is not decremented.
  - A `fir_done` arriving on the same edge as the timeout takes priority, and no error is flagged.
- Undefined: there is no watchdog counter, `timeout_err` is tied to 0, and WAIT lasts indefinitely.

## Test plan
- **Reset:** hold `reset=0`, drive `s_valid=1` → all outputs 0 and `s_ready=1`. After release, a push of 0x1234 at edge t gives `fir_valid` in cycle t+1, `fir_data=0x1234`, and `sample_count=1`.
- **Back-to-back:** push 0x0001..0x0005, with `fir_done` pulsed 200 cycles after each `fir_valid` → 5 single-cycle `fir_valid` pulses in order. Each one comes exactly one cycle after its `fir_done` edge, and `fir_data` is stable throughout each WAIT.
- **Backpressure:** hold `fir_done=0` and push 10 samples with `FIFO_DEPTH=8` → one sample issued, 8 buffered, `s_ready=0`. The 10th is held upstream and accepted after the next `fir_done`.
- **Frame limit:** with `INPUT_LENGTH=4`, push 6 samples and answer every issue → exactly 4 issues, then `frame_full=1` and 2 samples remain in the FIFO; a further `fir_done` is ignored.
- **Timeout** (macro defined, `TIMEOUT_CYCLES=16`): issue one sample with no `fir_done` → `timeout_err=1` after 16 WAIT cycles and the state returns to IDLE. With the macro undefined, `timeout_err` stays 0 and `busy` stays 1.
- **Async reset in WAIT with a full FIFO:** `reset` low mid-cycle → outputs clear without a clock edge. After release, there is no `fir_valid` until a new push.
